// File: rtl/spike_aer_if.sv
// Address-event output channel: event word plus valid/ready handshake.
interface spike_aer_if #(
   parameter int EV_W = 13
) ();
   logic [EV_W-1:0] aer_data;
   logic            aer_valid;
   logic            aer_ready;

   modport master (output aer_data, aer_valid, input aer_ready);
   modport slave  (input aer_data, aer_valid, output aer_ready);
endinterface

// File: rtl/spike_aer_encoder.sv
// Turns the delta modulator's round-robin spike stream into {ts, pol, ch}
// address events, queued in a first-word-fall-through FIFO.
module spike_aer_encoder #(
   parameter  int CHANNELS   = 16,
   parameter  int TS_WIDTH   = 8,
   parameter  int FIFO_DEPTH = 16,
   localparam int CH_W       = $clog2(CHANNELS),
   localparam int EV_W       = TS_WIDTH + 1 + CH_W,
   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1),
   localparam int AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             pos_spike,
   input  logic             neg_spike,
   input  logic             sync,
   spike_aer_if.master      aer,
   output logic [LVL_W-1:0] fifo_level,
   output logic             overflow,
   output logic [15:0]      drop_cnt
);

   logic [CH_W-1:0]     ch_cnt;
   logic [CH_W-1:0]     eff_ch;
   logic [TS_WIDTH-1:0] ts_cnt;
   logic [EV_W-1:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic                last_ch;
   logic                ev_vld;
   logic                full;
   logic                push;
   logic                pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign eff_ch  = sync ? '0 : ch_cnt;
   assign last_ch = (eff_ch == CH_W'(CHANNELS - 1));
   // {1,1} is illegal and treated as no event at all (not a drop)
   assign ev_vld  = in_valid & (pos_spike ^ neg_spike);
   // fullness is taken before any same-cycle pop, so a full FIFO drops even while draining
   assign full    = (fifo_level == LVL_W'(FIFO_DEPTH));
   assign push    = ev_vld & ~full;
   assign pop     = aer.aer_valid & aer.aer_ready;

   assign aer.aer_valid = (fifo_level != '0);
   assign aer.aer_data  = aer.aer_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ch_cnt     <= '0;
         ts_cnt     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         if (in_valid) begin
            ch_cnt <= last_ch ? '0 : eff_ch + CH_W'(1);
            if (last_ch)
               ts_cnt <= ts_cnt + TS_WIDTH'(1);
         end
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (ev_vld && full) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF)
               drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // Storage carries no reset; validity is tracked solely by the pointers and level.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {ts_cnt, pos_spike, eff_ch};
   end

endmodule
